ext_mem_arbiter: RTL
====================

Name: ext_mem_arbiter

Overview:
- Shares one single-port external memory between NB_PORTS on-chip requesters, such as feature fetch, kernel fetch and partial-sum spill.
- Performs one access (read or write) per cycle, using round-robin arbitration.
- Routes read data back to the requesting port after a fixed READ_LATENCY.
- Keeps read and write word counters for bandwidth accounting.
- Sits between top_chip's datapath clients and the memory instance in the system wrapper. It replaces the pseudo-2-port connection.

Parameters:
- NB_PORTS, 3, number of requester ports (>=1).
- ADDR_WIDTH, 20, memory word-address width.
- DATA_WIDTH, 32, memory word width.
- READ_LATENCY, 1, cycles from read handshake to rsp_valid (>=1). The memory returns qout 1 cycle after read_en; the block adds READ_LATENCY-1 register stages.
- CNT_WIDTH, 32, width of the bandwidth counters.

Ports:
- clk  in  1  clock
- arst_in  in  1  asynchronous reset, active-high
- req_valid  in  NB_PORTS  request valid, one bit per port
- req_ready  out  NB_PORTS  grant; a handshake occurs when valid&ready
- req_write  in  NB_PORTS  1=write, 0=read
- req_addr  in  NB_PORTS*ADDR_WIDTH  packed addresses; port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NB_PORTS*DATA_WIDTH  packed write data
- rsp_valid  out  NB_PORTS  read data valid for port i
- rsp_data  out  DATA_WIDTH  read data, shared bus (at most one rsp_valid bit is high)
- mem_addr  out  ADDR_WIDTH  memory address (single port)
- mem_read_en  out  1  memory read enable
- mem_write_en  out  1  memory write enable
- mem_din  out  DATA_WIDTH  memory write data
- mem_qout  in  DATA_WIDTH  memory read data, valid 1 cycle after mem_read_en
- clear_counters  in  1  synchronous clear of both counters
- rd_count  out  CNT_WIDTH  reads performed, saturating
- wr_count  out  CNT_WIDTH  writes performed, saturating
- outstanding  out  $clog2(READ_LATENCY+1)  reads in flight

Behaviour:
- Reset (arst_in=1, asynchronous):
  - rr_ptr=0, counters=0, response pipeline cleared.
  - req_ready, rsp_valid, mem_read_en and mem_write_en are all 0; rsp_data=0; outstanding=0.
- Arbitration (combinational, same cycle):
  - Grant the first port with req_valid=1, searching from rr_ptr upward and wrapping modulo NB_PORTS.
  - Exactly one req_ready bit is high when any request is valid; none otherwise.
  - On a handshake, rr_ptr <= (granted+1) mod NB_PORTS at the clock edge. With no handshake, rr_ptr holds.
- Memory drive:
  - mem_addr, mem_din, mem_read_en (=~req_write) and mem_write_en (=req_write) come from the granted port in the handshake cycle.
  - With no grant, both enables are 0; address and data are don't-care.
- Read response:
  - The port id and a valid bit enter a READ_LATENCY-deep shift pipeline.
  - rsp_valid[id] is high exactly READ_LATENCY cycles after the handshake, for 1 cycle, with rsp_data equal to the memory word at that address.
  - Back-to-back reads give back-to-back responses, in request order.
- Ordering: accesses are serialised, so a read granted after a write to the same address returns the new data.
- Requester rule: req_* must stay stable while valid&!ready. The block does not check this.
- Counters:
  - +1 on each read or write handshake; saturate at all-ones, no wrap.
  - clear_counters takes priority: the counter loads 1 if that same cycle has a handshake of its type, else 0.
- outstanding: +1 on a read handshake, -1 when rsp_valid fires; both in one cycle leaves it unchanged.
- Reset mid-operation: in-flight responses are dropped and not delivered after reset release.

Decomposition:
- Package ext_mem_pkg:
  - port_id_t typedef (width $clog2(NB_PORTS), minimum 1).
  - Access-type enum {ACC_READ, ACC_WRITE}.
  - Counter-saturation constant helper.
- Sub-module rr_arbiter (NB_PORTS): request vector in, one-hot grant plus encoded id out, rr_ptr register inside, advanced by a handshake strobe.

Test Plan:
- Reset and idle: assert arst_in for 3 cycles with all req_valid high -> req_ready=0, mem enables=0, counters=0. After release, the first grant goes to port 0.
- Round-robin fairness: all 3 ports reading continuously for 6 cycles -> grants 0,1,2,0,1,2; rd_count=6; each port gets 2 rsp_valid pulses.
- Read latency, READ_LATENCY=3:
  - Port 1 writes 0xDEADBEEF to addr 0x10, then reads 0x10 on the next cycle.
  - Expect rsp_valid[1] exactly 3 cycles after the read handshake, with rsp_data=0xDEADBEEF.
  - wr_count=1, rd_count=1.
- Skip idle ports: only port 2 requests, rr_ptr=0 -> port 2 is granted immediately; rr_ptr becomes 0 (wrap).
- Counter clear/saturate:
  - CNT_WIDTH=4 with 20 reads -> rd_count=15.
  - clear_counters asserted in the same cycle as a read handshake -> rd_count=1, wr_count=0.
- Reset mid-flight: READ_LATENCY=3; read handshake, then arst_in pulse 1 cycle later -> no rsp_valid after release; outstanding=0.

Source files
------------

// File: rtl/ext_mem_pkg.sv
// Shared types and constants for the external memory arbiter.
// Imported by the arbiter top and its round-robin sub-block.
package ext_mem_pkg;

  localparam int unsigned NB_PORTS_DFLT = 3;

  function automatic int unsigned id_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [id_w(NB_PORTS_DFLT)-1:0] port_id_t;

  typedef enum logic {
    ACC_READ  = 1'b0,
    ACC_WRITE = 1'b1
  } acc_e;

  // All-ones value of a w-bit counter, for w up to 64.
  function automatic logic [63:0] sat_max(int unsigned w);
    return (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus encoded id.
// Pointer advances past the winner only on a handshake.
module rr_arbiter
  import ext_mem_pkg::*;
#(
  parameter int unsigned NB_PORTS = 3,
  localparam int unsigned IDW = id_w(NB_PORTS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NB_PORTS-1:0] req_i,
  input  logic                hs_i,
  output logic [NB_PORTS-1:0] gnt_o,
  output logic [IDW-1:0]      gnt_id_o,
  output logic                any_o
);

  logic [IDW-1:0] ptr_q, ptr_d;

  always_comb begin
    int unsigned idx;
    idx      = 0;
    gnt_o    = '0;
    gnt_id_o = '0;
    any_o    = 1'b0;
    for (int unsigned k = 0; k < NB_PORTS; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NB_PORTS) idx = idx - NB_PORTS;
      if (!any_o && req_i[idx]) begin
        any_o      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_id_o   = IDW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (hs_i) begin
      if (gnt_id_o == IDW'(NB_PORTS - 1)) ptr_d = '0;
      else                                ptr_d = gnt_id_o + IDW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ext_mem_arbiter.sv
// Single-port external memory shared by NB_PORTS requesters,
// with in-order read return and saturating bandwidth counters.
module ext_mem_arbiter
  import ext_mem_pkg::*;
#(
  parameter int unsigned NB_PORTS     = 3,
  parameter int unsigned ADDR_WIDTH   = 20,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned CNT_WIDTH    = 32,
  localparam int unsigned IDW = id_w(NB_PORTS),
  localparam int unsigned OW  = $clog2(READ_LATENCY + 1)
) (
  input  logic                           clk,
  input  logic                           arst_in,
  input  logic [NB_PORTS-1:0]            req_valid,
  output logic [NB_PORTS-1:0]            req_ready,
  input  logic [NB_PORTS-1:0]            req_write,
  input  logic [NB_PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NB_PORTS*DATA_WIDTH-1:0] req_wdata,
  output logic [NB_PORTS-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_data,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic                           mem_read_en,
  output logic                           mem_write_en,
  output logic [DATA_WIDTH-1:0]          mem_din,
  input  logic [DATA_WIDTH-1:0]          mem_qout,
  input  logic                           clear_counters,
  output logic [CNT_WIDTH-1:0]           rd_count,
  output logic [CNT_WIDTH-1:0]           wr_count,
  output logic [OW-1:0]                  outstanding
);

  localparam logic [63:0] CMAX64 = sat_max(CNT_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CMAX64[CNT_WIDTH-1:0];
  localparam int unsigned LAST = READ_LATENCY - 1;

  logic [NB_PORTS-1:0]   gnt;
  logic [IDW-1:0]        gnt_id;
  logic                  any;
  logic                  hs;
  acc_e                  acc;
  logic [DATA_WIDTH-1:0] rd_data;

  logic [READ_LATENCY-1:0] pv_q;
  logic [IDW-1:0]          pid_q [READ_LATENCY];
  logic [CNT_WIDTH-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [OW-1:0]           os_q, os_d;

  // Grants are suppressed while reset is held.
  assign hs        = any & ~arst_in;
  assign req_ready = gnt & {NB_PORTS{~arst_in}};

  rr_arbiter #(.NB_PORTS(NB_PORTS)) u_arb (
    .clk      (clk),
    .rst      (arst_in),
    .req_i    (req_valid),
    .hs_i     (hs),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id),
    .any_o    (any)
  );

  always_comb begin
    acc          = acc_e'(req_write[gnt_id]);
    mem_addr     = req_addr[32'(gnt_id)*ADDR_WIDTH +: ADDR_WIDTH];
    mem_din      = req_wdata[32'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];
    mem_read_en  = hs && (acc == ACC_READ);
    mem_write_en = hs && (acc == ACC_WRITE);
  end

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      pv_q <= '0;
      for (int unsigned j = 0; j < READ_LATENCY; j++) pid_q[j] <= '0;
    end else begin
      pv_q[0]  <= mem_read_en;
      pid_q[0] <= gnt_id;
      for (int unsigned j = 1; j < READ_LATENCY; j++) begin
        pv_q[j]  <= pv_q[j-1];
        pid_q[j] <= pid_q[j-1];
      end
    end
  end

  // The memory itself supplies the first cycle of latency.
  if (READ_LATENCY > 1) begin : g_dpipe
    logic [DATA_WIDTH-1:0] dq_q [READ_LATENCY-1];
    always_ff @(posedge clk or posedge arst_in) begin
      if (arst_in) begin
        for (int unsigned j = 0; j < READ_LATENCY-1; j++) dq_q[j] <= '0;
      end else begin
        dq_q[0] <= mem_qout;
        for (int unsigned j = 1; j < READ_LATENCY-1; j++) dq_q[j] <= dq_q[j-1];
      end
    end
    assign rd_data = dq_q[READ_LATENCY-2];
  end else begin : g_dnone
    assign rd_data = mem_qout;
  end

  always_comb begin
    rsp_valid = '0;
    if (pv_q[LAST]) rsp_valid[pid_q[LAST]] = 1'b1;
    rsp_data = pv_q[LAST] ? rd_data : '0;
  end

  always_comb begin
    rd_d = rd_q;
    wr_d = wr_q;
    if (clear_counters) begin
      rd_d = CNT_WIDTH'(mem_read_en);
      wr_d = CNT_WIDTH'(mem_write_en);
    end else begin
      if (mem_read_en && rd_q != CNT_MAX)  rd_d = rd_q + CNT_WIDTH'(1);
      if (mem_write_en && wr_q != CNT_MAX) wr_d = wr_q + CNT_WIDTH'(1);
    end
    os_d = os_q + OW'(mem_read_en) - OW'(pv_q[LAST]);
  end

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      rd_q <= '0;
      wr_q <= '0;
      os_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      os_q <= os_d;
    end
  end

  assign rd_count    = rd_q;
  assign wr_count    = wr_q;
  assign outstanding = os_q;

endmodule
